// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-sequence detector.
//
// Watches a qualified serial bit stream and flags every completed
// occurrence of a runtime-programmable pattern of 1..MAX_LEN bits.
// Matching is either overlapping or non-overlapping. A saturating
// counter records the number of matches.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   inp_bit     serial data bit
//   in_valid    inp_bit is sampled only while this is high
//   pattern     pattern[pat_len-1] is the first bit received, pattern[0] the last
//   pat_len     active pattern length, legal range 1..MAX_LEN
//   overlap_en  1 = overlapping matches, 0 = history restarts after a match
//   clear       synchronous clear of history, fill and match_count
//   seq_seen    registered one-cycle match pulse
//   match_count saturating match counter
//   cfg_err     combinational flag for an illegal pat_len
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               in_valid,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               clear,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               seq_seen_q, seq_seen_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  assign cfg_err = (pat_len == '0) || (pat_len > FILL_MAX);

  always_comb begin
    // Mask keeps only the low pat_len history bits in the comparison.
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < pat_len);
    end

    hist_shift = {hist_q[MAX_LEN-2:0], inp_bit};
    fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    // Match is judged on the post-shift history and fill so that the
    // completing bit is part of the compare in the same edge.
    match = in_valid && !clear && !cfg_err &&
            (fill_inc >= pat_len) &&
            (((hist_shift ^ pattern) & len_mask) == '0);

    hist_d     = hist_q;
    fill_d     = fill_q;
    count_d    = count_q;
    seq_seen_d = 1'b0;

    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (in_valid) begin
      hist_d     = hist_shift;
      // Non-overlap mode demands pat_len fresh bits after each match.
      fill_d     = (match && !overlap_en) ? '0 : fill_inc;
      seq_seen_d = match;
      if (match && (count_q != CNT_MAX)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      seq_seen_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      seq_seen_q <= seq_seen_d;
    end
  end

  assign seq_seen    = seq_seen_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               inp_bit;
  logic               in_valid;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap_en;
  logic               clear;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .inp_bit    (inp_bit),
    .in_valid   (in_valid),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .clear      (clear),
    .seq_seen   (seq_seen),
    .match_count(match_count),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic seen;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the list of bits received since the last reset/clear,
  // how many bits count towards a match since the last restart, and the
  // number of matches so far.
  bit mbits[$];
  int mfill;
  int mcnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit cfg_ok();
    return (pat_len >= 1) && (pat_len <= MAX_LEN);
  endfunction

  task automatic model_reset();
    mbits.delete();
    mfill = 0;
    mcnt  = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr, output exp_t e);
    bit hit;
    e.seen = 1'b0;
    if (clr) begin
      model_reset();
    end else if (v) begin
      mbits.push_back(b);
      if (mbits.size() > MAX_LEN) void'(mbits.pop_front());
      mfill++;
      hit = cfg_ok() && (mfill >= int'(pat_len));
      if (hit) begin
        for (int k = 0; k < int'(pat_len); k++) begin
          if (mbits[mbits.size() - 1 - k] != pattern[k]) hit = 0;
        end
      end
      if (hit) begin
        if (mcnt < CNT_SAT) mcnt++;
        if (!overlap_en) mfill = 0;
      end
      e.seen = hit;
    end
    e.cnt = mcnt;
  endtask

  // Called at posedge+2; returns at the next posedge+2.
  task automatic step(input logic v, input logic b, input logic clr);
    exp_t e;
    inp_bit  = b;
    in_valid = v;
    clear    = clr;
    #1;
    chk("cfg_err", cfg_err, !cfg_ok());
    model_step(v, b, clr, e);
    @(posedge clk);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic run_bits(input logic [31:0] bits, input int n);
    logic [31:0] w;
    w = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0);
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    pattern    = p;
    pat_len    = l;
    overlap_en = ov;
  endtask

  // Monitor: every cycle after a sampled edge the DUT presents a result.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("seq_seen", seq_seen, mon_e.seen);
      chk("match_count", match_count, mon_e.cnt);
    end
  end

  initial begin
    reset    = 1'b1;
    inp_bit  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    set_cfg(8'b0000_1011, 4, 1'b1);
    model_reset();
    #1 reset = 1'b0;
    #6;
    chk("reset_seq_seen", seq_seen, 0);
    chk("reset_count", match_count, 0);
    #5 reset = 1'b1;
    @(posedge clk);
    #2;

    // Overlapping 1011 in 1011011: pulses after bits 4 and 7.
    run_bits(32'b1011011, 7);
    chk("ovl_count", match_count, 2);
    step(1'b0, 1'b0, 1'b1);

    // Same stream, non-overlapping: one pulse only.
    set_cfg(8'b0000_1011, 4, 1'b0);
    run_bits(32'b1011011, 7);
    chk("novl_count", match_count, 1);
    step(1'b0, 1'b0, 1'b1);

    // Full-length pattern: no pulse before eight valid bits.
    set_cfg(8'b1010_1010, 8, 1'b1);
    run_bits(32'b1010101010, 10);
    chk("len8_count", match_count, 2);
    step(1'b0, 1'b0, 1'b1);

    // Idle cycles with toggling data are ignored.
    set_cfg(8'b0000_1011, 4, 1'b1);
    run_bits(32'b10, 2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_bits(32'b11, 2);
    chk("idle_count", match_count, 1);
    step(1'b0, 1'b0, 1'b1);

    // pat_len==1 with saturation, then clear beats a matching bit.
    set_cfg(8'b0000_0001, 1, 1'b0);
    for (int i = 0; i < CNT_SAT + 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("sat_count", match_count, CNT_SAT);
    step(1'b1, 1'b1, 1'b1);
    chk("clear_count", match_count, 0);
    chk("clear_seen", seq_seen, 0);

    // Illegal lengths never match.
    set_cfg(8'b0000_0000, 0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    set_cfg(8'b1111_1111, 9, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("cfgerr_count", match_count, 0);
    step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a pulse.
    set_cfg(8'b0000_1011, 4, 1'b1);
    run_bits(32'b1011, 4);
    chk("pre_reset_pulse", seq_seen, 1);
    #1;
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("async_seq_seen", seq_seen, 0);
    chk("async_count", match_count, 0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;

    // Randomized traffic with live configuration changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pattern    = MAX_LEN'($urandom);
        pat_len    = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                                 : LEN_W'($urandom_range(1, 4));
        overlap_en = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 2));
    end

    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
